hex_scan_scheduler: RTL

HEX_SCAN_SCHEDULER -- requirements
Module: hex_scan_scheduler

---
 rtl/hex_scan_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/hex_scan_scheduler.sv
// rtl/hex_scan_scheduler.sv - four-digit multiplexed hex display scan scheduler with frame-synchronous shadow load.
// Optional macro LEADING_ZERO_BLANK_EN: keep leading zero digits (n>0, no point) dark.
module hex_scan_scheduler #(
  parameter int DRIVE_CYCLES = 50000,
  parameter int GAP_CYCLES   = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_value,
  input  logic [3:0]  load_points,
  output logic [3:0]  bin,
  output logic        point,
  output logic [3:0]  dig_sel,
  output logic        frame_tick
);

  typedef enum logic [1:0] {PARK, DRIVE, GAP} state_t;

  localparam logic [19:0] DRIVE_LAST = 20'(DRIVE_CYCLES - 1);
  localparam logic [19:0] GAP_LAST   = 20'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [19:0] cnt_q, cnt_d;
  logic [15:0] disp_val_q, disp_val_d;
  logic [3:0]  disp_pts_q, disp_pts_d;
  logic [15:0] sh_val_q, sh_val_d;
  logic [3:0]  sh_pts_q, sh_pts_d;
  logic        pend_q, pend_d;
  logic        init_q;
  logic        accept;
  logic        blank;

  assign load_ready = init_q & ~pend_q;
  assign accept     = load_valid & load_ready;
  assign bin        = disp_val_q[{idx_q, 2'b00} +: 4];
  assign point      = disp_pts_q[idx_q];

`ifdef LEADING_ZERO_BLANK_EN
  logic [15:0] upper;
  assign upper = disp_val_q >> {idx_q, 2'b00};
  assign blank = (idx_q != 2'd0) && (upper == 16'h0000) && !disp_pts_q[idx_q];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    disp_val_d = disp_val_q;
    disp_pts_d = disp_pts_q;
    sh_val_d   = sh_val_q;
    sh_pts_d   = sh_pts_q;
    pend_d     = pend_q;
    frame_tick = 1'b0;
    dig_sel    = 4'b1111;
    case (state_q)
      PARK: begin
        if (enable) begin
          state_d = DRIVE;
          idx_d   = 2'd0;
          cnt_d   = 20'd0;
        end
      end
      DRIVE: begin
        dig_sel = blank ? 4'b1111 : ~(4'b0001 << idx_q);
        if (!enable) begin
          state_d = PARK;
          cnt_d   = 20'd0;
        end else if (cnt_q == DRIVE_LAST) begin
          state_d = GAP;
          cnt_d   = 20'd0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      GAP: begin
        if (!enable) begin
          state_d = PARK;
          cnt_d   = 20'd0;
        end else if (cnt_q == GAP_LAST) begin
          state_d    = DRIVE;
          cnt_d      = 20'd0;
          idx_d      = idx_q + 2'd1;
          frame_tick = (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: state_d = PARK;
    endcase
    // Only a value already pending moves; a same-cycle handshake waits a frame.
    if (pend_q && (state_q == PARK || frame_tick)) begin
      disp_val_d = sh_val_q;
      disp_pts_d = sh_pts_q;
      pend_d     = 1'b0;
    end
    if (accept) begin
      sh_val_d = load_value;
      sh_pts_d = load_points;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PARK;
      idx_q      <= 2'd0;
      cnt_q      <= 20'd0;
      disp_val_q <= 16'h0000;
      disp_pts_q <= 4'b0000;
      sh_val_q   <= 16'h0000;
      sh_pts_q   <= 4'b0000;
      pend_q     <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      disp_val_q <= disp_val_d;
      disp_pts_q <= disp_pts_d;
      sh_val_q   <= sh_val_d;
      sh_pts_q   <= sh_pts_d;
      pend_q     <= pend_d;
      init_q     <= 1'b1;
    end
  end

endmodule
